// File: rtl/fetch_queue_if.sv
// Fetch queue bus: memory request channel, instruction output
// channel and redirect, grouped for the fetch_queue ports.
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic [CW-1:0] count;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst, inst_pc, count
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst, inst_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches and
// buffers {pc, word} pairs in a circular buffer; redirect flushes.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];

    logic          pop;
    logic          push;
    logic          has_room;
    logic [CW-1:0] count_nx;
    logic [31:0]   redir_pc;
    logic [31:0]   next_addr;

    assign redir_pc  = bus.redirect_pc & ~32'h3;
    assign next_addr = mem_addr_q + 32'd4;
    assign pop       = (count_q != '0) && bus.inst_ready && !bus.redirect;
    assign push      = (state_q == REQ) && bus.mem_ack && !bus.redirect;
    assign count_nx  = count_q - CW'(pop) + CW'(push);
    assign has_room  = count_nx < DEPTH_C;

    // Next-state: queue bookkeeping plus request FSM; redirect wins.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (bus.redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redir_pc;
        end else begin
            count_d = count_nx;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    state_d    = REQ;
                    mem_addr_d = redir_pc;
                end else if (has_room) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    if (bus.mem_ack) begin
                        mem_addr_d = redir_pc;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_d = next_addr;
                    if (has_room) begin
                        mem_addr_d = next_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                // Stale response is dropped; refetch from the new target.
                if (!bus.redirect && bus.mem_ack) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= mem_addr_q;
            word_mem[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req    = (state_q != IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = word_mem[rd_ptr_q];
    assign bus.inst_pc    = pc_mem[rd_ptr_q];
    assign bus.count      = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, backpressure,
// redirects, pointer wrap and asynchronous reset.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic auto_ack;
    logic ack_man;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word is the inverted address.
    always_comb begin
        bus.mem_ack   = auto_ack ? bus.mem_req : ack_man;
        bus.mem_rdata = ~bus.mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"},   32'(bus.mem_req), 32'd0);
        chk({tag, "_addr"},  bus.mem_addr, 32'h0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] exp_pc;
        int          pops;
        int          cyc;

        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;
        auto_ack        = 1'b0;
        ack_man         = 1'b0;

        // Reset state and first request
        #2 rst_n = 1'b0;
        #1;
        reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("start_req", 32'(bus.mem_req), 32'd1);
        chk("start_addr", bus.mem_addr, 32'h0);

        // Zero-latency memory, consumer always ready
        auto_ack       = 1'b1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            a = 32'(4 * i);
            chk("zl_pc", bus.inst_pc, a);
            chk("zl_word", bus.inst, ~a);
            chk("zl_count", 32'(bus.count), 32'd1);
        end

        // Backpressure: fill to DEPTH, then resume at 0x10
        bus.inst_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("bp_req", 32'(bus.mem_req), 32'd1);
        chk("bp_addr0", bus.mem_addr, 32'h0);
        repeat (4) step();
        chk("bp_full_cnt", 32'(bus.count), 32'd4);
        chk("bp_full_req", 32'(bus.mem_req), 32'd0);
        chk("bp_head_pc", bus.inst_pc, 32'h0);
        chk("bp_head_word", bus.inst, ~32'h0);
        repeat (2) step();
        chk("bp_hold_cnt", 32'(bus.count), 32'd4);
        chk("bp_hold_req", 32'(bus.mem_req), 32'd0);
        bus.inst_ready = 1'b1;
        step();
        chk("bp_rel_cnt", 32'(bus.count), 32'd3);
        chk("bp_rel_req", 32'(bus.mem_req), 32'd1);
        chk("bp_rel_addr", bus.mem_addr, 32'h10);
        chk("bp_rel_pc", bus.inst_pc, 32'h4);
        step();
        chk("bp_pc8", bus.inst_pc, 32'h8);
        step();
        chk("bp_pcc", bus.inst_pc, 32'hc);
        step();
        chk("bp_pc10", bus.inst_pc, 32'h10);
        chk("bp_word10", bus.inst, ~32'h10);
        chk("bp_cnt3", 32'(bus.count), 32'd3);

        // Redirect during a pending request: DISCARD path
        auto_ack = 1'b0;
        ack_man  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("late_rst_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_ack_cnt", 32'(bus.count), 32'd0);
        chk("idle_ack_addr", bus.mem_addr, 32'h0);
        step();
        step();
        ack_man = 1'b0;
        step();
        chk("dis_pend_addr", bus.mem_addr, 32'h8);
        chk("dis_pend_cnt", 32'(bus.count), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        step();
        bus.redirect = 1'b0;
        chk("dis_req", 32'(bus.mem_req), 32'd1);
        chk("dis_hold_addr", bus.mem_addr, 32'h8);
        step();
        chk("dis_wait_addr", bus.mem_addr, 32'h8);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("dis_drop_cnt", 32'(bus.count), 32'd0);
        chk("dis_drop_valid", 32'(bus.inst_valid), 32'd0);
        chk("dis_new_addr", bus.mem_addr, 32'h100);
        ack_man = 1'b1;
        step();
        chk("dis_pc", bus.inst_pc, 32'h100);
        chk("dis_word", bus.inst, ~32'h100);

        // Redirect coincident with ack and pop at count 2
        bus.inst_ready = 1'b0;
        step();
        chk("rd_cnt2", 32'(bus.count), 32'd2);
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        ack_man      = 1'b0;
        chk("rd_cnt0", 32'(bus.count), 32'd0);
        chk("rd_valid", 32'(bus.inst_valid), 32'd0);
        chk("rd_addr", bus.mem_addr, 32'h40);
        chk("rd_req", 32'(bus.mem_req), 32'd1);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("rd_pc", bus.inst_pc, 32'h40);
        chk("rd_cnt1", 32'(bus.count), 32'd1);

        // Pointer wrap with random consumer stalls vs reference order
        auto_ack = 1'b1;
        exp_pc   = 32'h40;
        pops     = 0;
        cyc      = 0;
        while (cyc < 200 && pops < 12) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            if (bus.inst_valid && bus.inst_ready) begin
                chk("wrap_pc", bus.inst_pc, exp_pc);
                chk("wrap_word", bus.inst, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            step();
            chk("wrap_cnt_le", 32'(bus.count <= 3'd4), 32'd1);
            cyc++;
        end
        chk("wrap_pops", 32'(pops), 32'd12);

        // Asynchronous reset mid-request with count 3
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        cyc = 0;
        while (cyc < 10 && bus.count != 3'd3) begin
            step();
            cyc++;
        end
        chk("ar_cnt3", 32'(bus.count), 32'd3);
        chk("ar_req", 32'(bus.mem_req), 32'd1);
        chk("ar_addr", bus.mem_addr, 32'h20c);
        rst_n = 1'b0;
        #1;
        reset_checks("ar");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_restart_req", 32'(bus.mem_req), 32'd1);
        chk("ar_restart_addr", bus.mem_addr, 32'h0);
        step();
        chk("ar_first_pc", bus.inst_pc, 32'h0);
        chk("ar_first_word", bus.inst, ~32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
